main_fifo_vc_demux: RTL and testbench
=====================================

Name: main_fifo_vc_demux

Overview:
- Downstream read controller for the main FIFO in the transmit path.
- Pops words from the main FIFO when it is non-empty and both virtual-channel FIFOs have room.
- Steers each word to the VC0 or VC1 FIFO according to its MSB (class bit).
- Provides the transmit-path state machine (RESET/INIT/IDLE/ACTIVE), a sticky overflow error and per-VC word counters.

Parameters:
- data_width, 6, word width; bit data_width-1 is the VC select.
- cnt_width, 8, width of the per-VC forwarded-word counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- init  in  1  active-low clear, shared with the main/VC FIFOs. Low = clear everything; high = run.
- main_empty  in  1  main FIFO empty flag.
- main_data  in  data_width  main FIFO data_out. Registered; valid the cycle after rd_enable, 0 otherwise.
- main_rd_enable  out  1  read strobe to the main FIFO.
- vc0_almost_full  in  1  VC0 FIFO almost-full.
- vc1_almost_full  in  1  VC1 FIFO almost-full.
- vc0_full  in  1  VC0 FIFO full.
- vc1_full  in  1  VC1 FIFO full.
- vc0_wr_enable  out  1  write strobe to VC0 FIFO.
- vc1_wr_enable  out  1  write strobe to VC1 FIFO.
- vc0_data  out  data_width  data to VC0 FIFO.
- vc1_data  out  data_width  data to VC1 FIFO.
- state  out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- idle  out  1  high iff state==IDLE.
- active  out  1  high iff state==ACTIVE.
- error  out  1  sticky VC overflow.
- vc0_count  out  cnt_width  words forwarded to VC0.
- vc1_count  out  cnt_width  words forwarded to VC1.

Behaviour:
- reset==0 at a clk edge:
  - state=RESET, error=0, both counts=0.
  - vc*_wr_enable=0, vc*_data=0, in-flight flag rd_pend=0.
  - main_rd_enable=0 (combinational gate on state).
- FSM, evaluated only when reset==1:
  - RESET -> INIT, unconditionally.
  - INIT -> IDLE when init==1; stays in INIT while init==0.
  - IDLE -> ACTIVE when main_empty==0.
  - ACTIVE -> IDLE when main_empty==1 && rd_pend==0 && no VC write in the current cycle.
  - Any state except RESET -> INIT when init==0. This also clears rd_pend, error, counts, vc*_wr_enable and vc*_data in the same edge.
- Read issue (combinational):
  - main_rd_enable = (state==IDLE || state==ACTIVE) && init && !main_empty && !vc0_almost_full && !vc1_almost_full.
  - Both VC flags gate the read because the destination is unknown until the word arrives.
- Pipeline:
  - Edge E0: main_rd_enable==1 sets rd_pend=1.
  - Edge E1: rd_pend==1 latches main_data into vcX_data and pulses vcX_wr_enable for exactly one cycle. X = main_data[data_width-1].
  - The non-selected wr_enable stays 0 and its data holds its previous value.
  - Latency: read strobe in cycle t -> VC write strobe in cycle t+2.
  - Sustained throughput is 1 word/cycle with back-to-back reads.
  - rd_pend is cleared at E1 unless a new read is issued.
- Slack requirement: up to 2 words are in flight after almost_full rises. VC FIFO thresholds must leave >= 2 free entries; this is a system requirement, not checked here.
- Overflow:
  - If at E1 the selected vcX_full==1, the word is dropped: wr_enable stays 0 and the count is not incremented.
  - error is set to 1 and held until reset or init low.
- Counters:
  - vcX_count increments by 1 on each issued vcX write and wraps modulo 2^cnt_width.
  - Counters reset only by reset or init low.
- Simultaneous events:
  - reset low overrides init.
  - init low overrides any in-flight word, which is discarded with no write.
- A read issued in IDLE is legal; the state moves to ACTIVE on the same edge.

Test Plan:
- Reset: reset=0 for 2 cycles -> state=0, error=0, counts=0, all strobes 0. Then reset=1, init=0 -> state=1. Then init=1 -> state=2, idle=1.
- Steering: main supplies 6'b100101 then 6'b000011 back-to-back, VC flags low -> main_rd_enable high 2 cycles. vc1_wr_enable pulses with vc1_data=6'h25 at t+2. vc0_wr_enable pulses with vc0_data=6'h03 at t+3. vc1_count=1, vc0_count=1. FSM ends in IDLE once empty.
- Backpressure: vc0_almost_full=1 with main_empty=0 -> main_rd_enable=0, state=ACTIVE, no writes. Release -> reads resume the next cycle.
- Overflow: word 6'b000111 in flight with vc0_full=1 at its write edge -> vc0_wr_enable=0, vc0_count unchanged, error=1 and held 10 cycles. init pulse low -> error=0.
- Counter wrap (cnt_width=8): forward 256 VC0 words -> vc0_count returns to 0, error=0.
- Init mid-flight: init=0 the cycle after a read -> no VC write, state=INIT, rd_pend cleared, counts=0.

Source files
------------

// File: rtl/main_fifo_vc_demux.sv
// Main FIFO read controller for the transmit path: pops words when both VC
// FIFOs have room and steers each word to VC0/VC1 by its MSB. Also provides
// the RESET/INIT/IDLE/ACTIVE state machine, a sticky overflow flag and
// per-VC forwarded-word counters.
module main_fifo_vc_demux #(
  parameter int data_width = 6,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  main_empty,
  input  logic [data_width-1:0] main_data,
  output logic                  main_rd_enable,
  input  logic                  vc0_almost_full,
  input  logic                  vc1_almost_full,
  input  logic                  vc0_full,
  input  logic                  vc1_full,
  output logic                  vc0_wr_enable,
  output logic                  vc1_wr_enable,
  output logic [data_width-1:0] vc0_data,
  output logic [data_width-1:0] vc1_data,
  output logic [1:0]            state,
  output logic                  idle,
  output logic                  active,
  output logic                  error,
  output logic [cnt_width-1:0]  vc0_count,
  output logic [cnt_width-1:0]  vc1_count
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   rd_pend;
  logic   vc_sel;

  assign vc_sel = main_data[data_width-1];

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= ST_RESET;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; init low pulls every state but RESET back to INIT
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_RESET:  nxt_state = ST_INIT;
      ST_INIT:   nxt_state = init ? ST_IDLE : ST_INIT;
      ST_IDLE:   nxt_state = !init ? ST_INIT :
                             (!main_empty ? ST_ACTIVE : ST_IDLE);
      ST_ACTIVE: nxt_state = !init ? ST_INIT :
                             ((main_empty && !rd_pend && !vc0_wr_enable && !vc1_wr_enable)
                              ? ST_IDLE : ST_ACTIVE);
      default:   nxt_state = ST_RESET;
    endcase
  end

  // State decode and read issue; both VC flags gate the read because the
  // destination is unknown until the word arrives
  always_comb begin
    state          = cur_state;
    idle           = (cur_state == ST_IDLE);
    active         = (cur_state == ST_ACTIVE);
    main_rd_enable = ((cur_state == ST_IDLE) || (cur_state == ST_ACTIVE)) &&
                     init && !main_empty && !vc0_almost_full && !vc1_almost_full;
  end

  // Read pipeline, VC write steering, overflow flag and counters
  always_ff @(posedge clk) begin
    if (!reset || !init) begin
      rd_pend       <= 1'b0;
      error         <= 1'b0;
      vc0_wr_enable <= 1'b0;
      vc1_wr_enable <= 1'b0;
      vc0_data      <= '0;
      vc1_data      <= '0;
      vc0_count     <= '0;
      vc1_count     <= '0;
    end else begin
      rd_pend       <= main_rd_enable;
      vc0_wr_enable <= 1'b0;
      vc1_wr_enable <= 1'b0;
      if (rd_pend) begin
        if (vc_sel) begin
          if (vc1_full) begin
            error <= 1'b1;
          end else begin
            vc1_wr_enable <= 1'b1;
            vc1_data      <= main_data;
            vc1_count     <= vc1_count + cnt_width'(1);
          end
        end else begin
          if (vc0_full) begin
            error <= 1'b1;
          end else begin
            vc0_wr_enable <= 1'b1;
            vc0_data      <= main_data;
            vc0_count     <= vc0_count + cnt_width'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_main_fifo_vc_demux.sv
// Bench for main_fifo_vc_demux: a small behavioural main FIFO feeds the DUT;
// a vector table covers reset/init/gating, hand sequences cover the
// multi-cycle corners.
module tb_main_fifo_vc_demux;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          init;
  logic          main_empty;
  logic [DW-1:0] main_data;
  logic          main_rd_enable;
  logic          vc0_almost_full, vc1_almost_full;
  logic          vc0_full, vc1_full;
  logic          vc0_wr_enable, vc1_wr_enable;
  logic [DW-1:0] vc0_data, vc1_data;
  logic [1:0]    state;
  logic          idle, active, error;
  logic [CW-1:0] vc0_count, vc1_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural main FIFO: registered data, 0 when not read
  logic [DW-1:0] mem [0:1023];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic          use_model = 1'b0;
  logic          tb_empty  = 1'b1;

  assign main_empty = use_model ? (rd_ptr == wr_ptr) : tb_empty;

  always @(posedge clk) begin
    if (main_rd_enable) begin
      main_data <= mem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end else begin
      main_data <= '0;
    end
  end

  main_fifo_vc_demux #(.data_width(DW), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .main_empty(main_empty), .main_data(main_data), .main_rd_enable(main_rd_enable),
    .vc0_almost_full(vc0_almost_full), .vc1_almost_full(vc1_almost_full),
    .vc0_full(vc0_full), .vc1_full(vc1_full),
    .vc0_wr_enable(vc0_wr_enable), .vc1_wr_enable(vc1_wr_enable),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .state(state), .idle(idle), .active(active), .error(error),
    .vc0_count(vc0_count), .vc1_count(vc1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[9:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      if (idle) break;
      @(negedge clk);
    end
    check(name, {31'd0, idle}, 32'd1);
  endtask

  task automatic init_pulse();
    init = 1'b0;
    @(negedge clk);
    check("init_pulse_state", {30'd0, state}, 32'd1);
    init = 1'b1;
    @(negedge clk);
    check("init_pulse_idle", {30'd0, state}, 32'd2);
  endtask

  typedef struct {
    logic       rst, ini, emp, af0, af1;
    logic       rd;
    logic [1:0] st;
    logic       wr0, wr1;
  } vec_t;

  vec_t tbl [16];
  int   seen;

  initial begin
    // rst ini emp af0 af1 | rd(before edge) state wr0 wr1 (after edge)
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};

    mem[0] = 6'h2A;
    reset = 1'b0; init = 1'b0;
    vc0_almost_full = 1'b0; vc1_almost_full = 1'b0;
    vc0_full = 1'b0; vc1_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // ---- vector table ----
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst; init = tbl[i].ini; tb_empty = tbl[i].emp;
      vc0_almost_full = tbl[i].af0; vc1_almost_full = tbl[i].af1;
      #1;
      check($sformatf("v%0d_rd", i), {31'd0, main_rd_enable}, {31'd0, tbl[i].rd});
      @(posedge clk); #1;
      check($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
      check($sformatf("v%0d_idle", i), {31'd0, idle}, {31'd0, tbl[i].st == 2'd2});
      check($sformatf("v%0d_active", i), {31'd0, active}, {31'd0, tbl[i].st == 2'd3});
      check($sformatf("v%0d_wr0", i), {31'd0, vc0_wr_enable}, {31'd0, tbl[i].wr0});
      check($sformatf("v%0d_wr1", i), {31'd0, vc1_wr_enable}, {31'd0, tbl[i].wr1});
      if (tbl[i].st == 2'd0) begin
        check($sformatf("v%0d_err", i), {31'd0, error}, 32'd0);
        check($sformatf("v%0d_cnt0", i), {24'd0, vc0_count}, 32'd0);
        check($sformatf("v%0d_cnt1", i), {24'd0, vc1_count}, 32'd0);
        check($sformatf("v%0d_d1", i), {26'd0, vc1_data}, 32'd0);
      end
      if (tbl[i].wr1) begin
        check($sformatf("v%0d_data1", i), {26'd0, vc1_data}, 32'h2A);
        check($sformatf("v%0d_count1", i), {24'd0, vc1_count}, 32'd1);
      end
      @(negedge clk);
    end

    // Hand over to the FIFO model
    wr_ptr = rd_ptr;
    use_model = 1'b1;
    init_pulse();
    check("reinit_cnt1", {24'd0, vc1_count}, 32'd0);

    // ---- steering: two words back-to-back ----
    push(6'b100101); push(6'b000011);
    #1 check("steer_rd0", {31'd0, main_rd_enable}, 32'd1);
    @(negedge clk);
    check("steer_rd1", {31'd0, main_rd_enable}, 32'd1);
    check("steer_active", {30'd0, state}, 32'd3);
    @(negedge clk);
    check("steer_wr1", {31'd0, vc1_wr_enable}, 32'd1);
    check("steer_wr0_low", {31'd0, vc0_wr_enable}, 32'd0);
    check("steer_d1", {26'd0, vc1_data}, 32'h25);
    check("steer_rd_off", {31'd0, main_rd_enable}, 32'd0);
    @(negedge clk);
    check("steer_wr0", {31'd0, vc0_wr_enable}, 32'd1);
    check("steer_wr1_low", {31'd0, vc1_wr_enable}, 32'd0);
    check("steer_d0", {26'd0, vc0_data}, 32'h03);
    check("steer_d1_hold", {26'd0, vc1_data}, 32'h25);
    check("steer_c0", {24'd0, vc0_count}, 32'd1);
    check("steer_c1", {24'd0, vc1_count}, 32'd1);
    @(negedge clk);
    check("steer_still_active", {30'd0, state}, 32'd3);
    wait_idle("steer_idle");

    // ---- backpressure ----
    vc0_almost_full = 1'b1;
    push(6'h01);
    #1 check("bp_rd_gated", {31'd0, main_rd_enable}, 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (vc0_wr_enable || vc1_wr_enable || main_rd_enable) seen++;
    end
    check("bp_active", {30'd0, state}, 32'd3);
    check("bp_no_activity", seen, 32'd0);
    vc0_almost_full = 1'b0;
    #1 check("bp_rd_resume", {31'd0, main_rd_enable}, 32'd1);
    @(negedge clk); @(negedge clk);
    check("bp_wr0", {31'd0, vc0_wr_enable}, 32'd1);
    check("bp_d0", {26'd0, vc0_data}, 32'h01);
    check("bp_c0", {24'd0, vc0_count}, 32'd2);
    wait_idle("bp_idle");

    // ---- overflow ----
    push(6'b000111);
    #1 check("ov_rd", {31'd0, main_rd_enable}, 32'd1);
    @(negedge clk);
    vc0_full = 1'b1;
    @(negedge clk);
    check("ov_wr0", {31'd0, vc0_wr_enable}, 32'd0);
    check("ov_c0", {24'd0, vc0_count}, 32'd2);
    check("ov_err", {31'd0, error}, 32'd1);
    vc0_full = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (error) seen++;
    end
    check("ov_err_held", seen, 32'd10);
    init_pulse();
    check("ov_err_clr", {31'd0, error}, 32'd0);
    check("ov_c0_clr", {24'd0, vc0_count}, 32'd0);

    // ---- counter wrap: 256 VC0 words ----
    for (int i = 0; i < 256; i++) push(DW'(i % 32));
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vc0_wr_enable) begin
        seen++;
        if (seen == 255) check("wrap_c255", {24'd0, vc0_count}, 32'd255);
      end
      if (idle && main_empty && seen > 0) break;
    end
    check("wrap_seen", seen, 32'd256);
    check("wrap_c0", {24'd0, vc0_count}, 32'd0);
    check("wrap_c1", {24'd0, vc1_count}, 32'd0);
    check("wrap_err", {31'd0, error}, 32'd0);
    check("wrap_idle", {31'd0, idle}, 32'd1);

    // ---- init low mid-flight ----
    push(6'h21);
    #1 check("mf_rd", {31'd0, main_rd_enable}, 32'd1);
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    check("mf_state", {30'd0, state}, 32'd1);
    check("mf_wr1", {31'd0, vc1_wr_enable}, 32'd0);
    check("mf_c0", {24'd0, vc0_count}, 32'd0);
    @(negedge clk);
    check("mf_wr1_late", {31'd0, vc1_wr_enable}, 32'd0);
    check("mf_c1", {24'd0, vc1_count}, 32'd0);
    init = 1'b1;
    @(negedge clk);
    check("mf_idle", {30'd0, state}, 32'd2);
    @(negedge clk);
    check("mf_stay_idle", {30'd0, state}, 32'd2);
    check("mf_no_write", {31'd0, vc0_wr_enable | vc1_wr_enable}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
